// File: rtl/data_memory.sv
// data_memory: byte-addressable word memory with a two-stage registered read
// path and byte-lane writes. Reads always return the full aligned word. Writes
// that are misaligned for their width, or that use the reserved width, are
// dropped and flagged with a one-cycle misaligned_err pulse.
// The byte-lane datapath is built for XLEN = 32 (four lanes, addr[1:0]).
module data_memory #(
  parameter int XLEN        = 32,
  parameter int DEPTH_WORDS = 1024
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  input  logic [XLEN-1:0] req_addr,
  input  logic            req_wenable,
  input  logic [1:0]      req_wwidth,
  input  logic [XLEN-1:0] req_wdata,
  output logic [XLEN-1:0] q,
  output logic            q_valid,
  output logic            misaligned_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int LANES = XLEN / 8;

  localparam logic [1:0] WIDTH_BYTE = 2'd0;
  localparam logic [1:0] WIDTH_HALF = 2'd1;
  localparam logic [1:0] WIDTH_WORD = 2'd2;

  logic [XLEN-1:0]  mem [DEPTH_WORDS];

  logic [IDX_W-1:0] req_idx;
  logic             wr_fire;
  logic             wr_aligned;
  logic [LANES-1:0] lane_sel;
  logic [LANES-1:0] wr_be;
  logic [XLEN-1:0]  wr_lanes;
  logic             wr_bad;

  logic             rd_valid_s1;
  logic [IDX_W-1:0] rd_idx_s1;

  // Address bits above the array size are ignored, so addresses wrap.
  logic             unused_addr_hi;
  assign unused_addr_hi = ^req_addr[XLEN-1:IDX_W+2];

  assign req_idx = req_addr[IDX_W+1:2];
  assign wr_fire = req_valid & req_wenable;

  // Decode write width into byte-lane enables and lane-replicated write data.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    wr_aligned = 1'b0;
    lane_sel   = '0;
    wr_lanes   = req_wdata;
    case (req_wwidth)
      WIDTH_BYTE: begin
        wr_aligned = 1'b1;
        lane_sel   = 4'b0001 << req_addr[1:0];
        wr_lanes   = {4{req_wdata[7:0]}};
      end
      WIDTH_HALF: begin
        wr_aligned = ~req_addr[0];
        lane_sel   = req_addr[1] ? 4'b1100 : 4'b0011;
        wr_lanes   = {2{req_wdata[15:0]}};
      end
      WIDTH_WORD: begin
        wr_aligned = (req_addr[1:0] == 2'b00);
        lane_sel   = 4'b1111;
        wr_lanes   = req_wdata;
      end
      default: begin
        wr_aligned = 1'b0;
        lane_sel   = '0;
      end
    endcase
    wr_be  = (wr_fire && wr_aligned) ? lane_sel : '0;
    wr_bad = wr_fire & ~wr_aligned;
  end

  // Byte-lane write into the storage array at the accepting edge.
  // NOTE: the array has no reset; its contents survive rst_n, and leaving it
  // out of the reset keeps it mappable onto block RAM.
  always_ff @(posedge clk) begin
    for (int l = 0; l < LANES; l++) begin
      if (wr_be[l]) begin
        mem[req_idx][8*l +: 8] <= wr_lanes[8*l +: 8];
      end
    end
  end

  // Read stage 1: capture the word index and the read-valid flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_s1 <= 1'b0;
      rd_idx_s1   <= '0;
    end else begin
      rd_valid_s1 <= req_valid & ~req_wenable;
      if (req_valid && !req_wenable) begin
        rd_idx_s1 <= req_idx;
      end
    end
  end

  // Read stage 2: register array data; q holds its value between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q       <= '0;
      q_valid <= 1'b0;
    end else begin
      q_valid <= rd_valid_s1;
      if (rd_valid_s1) begin
        // NOTE: non-blocking updates mean this samples the array as it was
        // before any write committed on the same edge, so a write right after
        // a read cannot leak into that read's result.
        q <= mem[rd_idx_s1];
      end
    end
  end

  // Flag a rejected write for one cycle after the edge that accepted it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misaligned_err <= 1'b0;
    end else begin
      misaligned_err <= wr_bad;
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// Testbench for data_memory: directed requests push hand-computed expected
// read data (with the cycle it is due) and expected error pulses into queues;
// an independent monitor pops and compares whenever the DUT presents output.
module tb_data_memory;

  localparam logic [1:0] W_B = 2'd0;
  localparam logic [1:0] W_H = 2'd1;
  localparam logic [1:0] W_W = 2'd2;
  localparam logic [1:0] W_R = 2'd3;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_wenable;
  logic [1:0]  req_wwidth;
  logic [31:0] req_wdata;
  logic [31:0] q;
  logic        q_valid;
  logic        misaligned_err;

  typedef struct {
    int          due;
    logic [31:0] data;
  } rd_exp_t;

  rd_exp_t rq[$];
  int      eq[$];
  int      cyc = 0;
  int      compared = 0;
  int      mismatched = 0;

  data_memory #(.XLEN(32), .DEPTH_WORDS(1024)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_addr       (req_addr),
    .req_wenable    (req_wenable),
    .req_wwidth     (req_wwidth),
    .req_wdata      (req_wdata),
    .q              (q),
    .q_valid        (q_valid),
    .misaligned_err (misaligned_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Write request; a rejected write expects an error pulse after its edge.
  task automatic wr(input logic [31:0] addr, input logic [1:0] width,
                    input logic [31:0] data, input bit bad);
    @(negedge clk);
    req_valid   = 1'b1;
    req_wenable = 1'b1;
    req_addr    = addr;
    req_wwidth  = width;
    req_wdata   = data;
    if (bad) eq.push_back(cyc + 1);
  endtask

  // Read request; expected word is due two edges after issue.
  task automatic rd(input logic [31:0] addr, input logic [31:0] exp,
                    input bit track);
    @(negedge clk);
    req_valid   = 1'b1;
    req_wenable = 1'b0;
    req_addr    = addr;
    req_wwidth  = W_R;
    req_wdata   = 32'hFFFF_FFFF;
    if (track) rq.push_back('{due: cyc + 2, data: exp});
  endtask

  // Idle cycle with write-looking garbage that must be ignored.
  task automatic idle(input logic [31:0] addr);
    @(negedge clk);
    req_valid   = 1'b0;
    req_wenable = 1'b1;
    req_addr    = addr;
    req_wwidth  = W_W;
    req_wdata   = 32'h0000_0000;
  endtask

  // Monitor: compare read data/latency and error pulses against the queues.
  initial begin
    rd_exp_t e;
    int      d;
    forever begin
      @(posedge clk);
      #1;
      if (q_valid === 1'b1) begin
        if (rq.size() == 0) begin
          check("q_valid_spurious", {31'b0, q_valid}, 32'd0);
        end else begin
          e = rq.pop_front();
          check("rd_data", q, e.data);
          check("rd_latency", 32'(cyc), 32'(e.due));
        end
      end else if (rq.size() != 0 && rq[0].due <= cyc) begin
        e = rq.pop_front();
        check("rd_missing", {31'b0, q_valid}, 32'd1);
      end
      if (misaligned_err === 1'b1) begin
        if (eq.size() == 0) begin
          check("err_spurious", {31'b0, misaligned_err}, 32'd0);
        end else begin
          d = eq.pop_front();
          check("err_cycle", 32'(cyc), 32'(d));
        end
      end else if (eq.size() != 0 && eq[0] <= cyc) begin
        d = eq.pop_front();
        check("err_missing", {31'b0, misaligned_err}, 32'd1);
      end
    end
  end

  initial begin
    rst_n       = 1'b1;
    req_valid   = 1'b0;
    req_addr    = '0;
    req_wenable = 1'b0;
    req_wwidth  = W_W;
    req_wdata   = '0;
    #3 rst_n = 1'b0;
    #1;
    check("reset_q", q, 32'd0);
    check("reset_q_valid", {31'b0, q_valid}, 32'd0);
    check("reset_err", {31'b0, misaligned_err}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Write then immediate read of the same word.
    wr(32'h10, W_W, 32'hDEAD_BEEF, 1'b0);
    rd(32'h10, 32'hDEAD_BEEF, 1'b1);

    // Sub-word merges; read at an unaligned address returns the full word.
    wr(32'h20, W_W, 32'h1122_3344, 1'b0);
    wr(32'h22, W_B, 32'h0000_00AA, 1'b0);
    wr(32'h20, W_H, 32'h0000_BBCC, 1'b0);
    rd(32'h23, 32'h11AA_BBCC, 1'b1);

    // Remaining lanes, with garbage in the unused upper data bits.
    wr(32'h30, W_W, 32'h0000_0000, 1'b0);
    wr(32'h31, W_B, 32'hFFFF_FF5A, 1'b0);
    wr(32'h33, W_B, 32'hFFFF_FFC3, 1'b0);
    wr(32'h32, W_H, 32'hABCD_1234, 1'b0);
    rd(32'h30, 32'h1234_5A00, 1'b1);

    // Rejected writes leave the word untouched; invalid cycles are ignored.
    wr(32'h04, W_W, 32'hCAFE_F00D, 1'b0);
    wr(32'h06, W_W, 32'hFFFF_FFFF, 1'b1);
    rd(32'h04, 32'hCAFE_F00D, 1'b1);
    wr(32'h05, W_H, 32'h0000_9999, 1'b1);
    wr(32'h04, W_R, 32'h7777_7777, 1'b1);
    wr(32'h07, W_H, 32'h0000_5555, 1'b1);
    idle(32'h04);
    rd(32'h04, 32'hCAFE_F00D, 1'b1);

    // Back-to-back reads, then q holds while idle.
    wr(32'h00, W_W, 32'hA0A0_A0A0, 1'b0);
    wr(32'h08, W_W, 32'hA8A8_A8A8, 1'b0);
    rd(32'h00, 32'hA0A0_A0A0, 1'b1);
    rd(32'h04, 32'hCAFE_F00D, 1'b1);
    rd(32'h08, 32'hA8A8_A8A8, 1'b1);
    idle(32'h08);
    idle(32'h08);
    idle(32'h08);
    check("q_hold", q, 32'hA8A8_A8A8);
    check("q_valid_idle", {31'b0, q_valid}, 32'd0);

    // Write right after a read does not affect that read.
    rd(32'h10, 32'hDEAD_BEEF, 1'b1);
    wr(32'h10, W_W, 32'h5555_5555, 1'b0);
    rd(32'h10, 32'h5555_5555, 1'b1);

    // Address wrap-around modulo 4 KiB.
    wr(32'h1000, W_W, 32'h0BAD_F00D, 1'b0);
    rd(32'h0000, 32'h0BAD_F00D, 1'b1);
    rd(32'h1004, 32'hCAFE_F00D, 1'b1);

    // Reset with a read in flight: outputs clear at once, read is dropped.
    rd(32'h08, 32'h0, 1'b0);
    @(negedge clk);
    req_valid = 1'b0;
    rst_n     = 1'b0;
    #1;
    check("rst_mid_q", q, 32'd0);
    check("rst_mid_q_valid", {31'b0, q_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rd(32'h10, 32'h5555_5555, 1'b1);
    rd(32'h20, 32'h11AA_BBCC, 1'b1);
    repeat (4) idle(32'h0);

    for (int i = 0; i < 20 && (rq.size() != 0 || eq.size() != 0); i++) begin
      @(negedge clk);
    end
    check("rd_queue_drained", 32'(rq.size()), 32'd0);
    check("err_queue_drained", 32'(eq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
